// File: rtl/tt_pkg.sv
// ============================================================================
// Module  : tt_pkg
// Brief   : Shared state encodings, mode constants and row evaluation helper
//           for the truth-table sweeper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_SWEEP = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  localparam logic TT_MODE_SOP = 1'b0;
  localparam logic TT_MODE_POS = 1'b1;

  // A listed maxterm makes its row evaluate to 0, so POS inverts the mask bit.
  function automatic logic tt_eval(input logic mask_bit, input logic mode);
    return (mode == TT_MODE_SOP) ? mask_bit : ~mask_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// Module  : truth_table_sweeper_if
// Brief   : Control/row-stream bundle of the truth-table sweeper.
//           TT_CHECK_EN adds expect_mask / mismatch_cnt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if #(
  parameter int N_VARS = 3
);
  logic                   start;
  logic                   mode;
  logic [2**N_VARS-1:0]   term_mask;
  logic                   out_ready;
  logic                   row_valid;
  logic [N_VARS-1:0]      row_idx;
  logic                   row_out;
  logic                   busy;
  logic                   done;
  logic [N_VARS:0]        ones_count;
`ifdef TT_CHECK_EN
  logic [2**N_VARS-1:0]   expect_mask;
  logic [N_VARS:0]        mismatch_cnt;

  modport master (
    output start, mode, term_mask, out_ready, expect_mask,
    input  row_valid, row_idx, row_out, busy, done, ones_count, mismatch_cnt
  );
  modport slave (
    input  start, mode, term_mask, out_ready, expect_mask,
    output row_valid, row_idx, row_out, busy, done, ones_count, mismatch_cnt
  );
`else
  modport master (
    output start, mode, term_mask, out_ready,
    input  row_valid, row_idx, row_out, busy, done, ones_count
  );
  modport slave (
    input  start, mode, term_mask, out_ready,
    output row_valid, row_idx, row_out, busy, done, ones_count
  );
`endif
endinterface

`default_nettype wire

// File: rtl/tt_row_counter.sv
// ============================================================================
// Module  : tt_row_counter
// Brief   : Row index counter with synchronous clear, enable and last flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_row_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  logic [WIDTH-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (en) begin
      r_idx <= r_idx + WIDTH'(1);
    end
  end

  assign idx  = r_idx;
  assign last = (r_idx == {WIDTH{1'b1}});

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module  : truth_table_sweeper
// Brief   : Streams the truth table of an SOP/POS term list one row per
//           handshake and counts the rows that evaluate to 1.
//           TT_CHECK_EN adds a per-row comparison against expect_mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_VARS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int ROWS = 2**N_VARS;

  tt_state_e          r_state;
  logic               r_mode;
  logic [ROWS-1:0]    r_mask;
  logic               r_row_valid;
  logic               r_row_out;
  logic               r_busy;
  logic               r_done;
  logic [N_VARS:0]    r_ones;

  logic               w_start;
  logic               w_hs;
  logic               w_last;
  logic [N_VARS-1:0]  w_idx;
  logic [N_VARS-1:0]  w_next_idx;

  assign w_start    = (r_state == TT_IDLE) && bus.start;
  assign w_hs       = r_row_valid && bus.out_ready;
  assign w_next_idx = w_idx + N_VARS'(1);

  // Index resets on the last accepted row so it already reads 0 in DONE.
  tt_row_counter #(
    .WIDTH (N_VARS)
  ) u_row_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start || (w_hs && w_last)),
    .en    (w_hs && !w_last),
    .idx   (w_idx),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TT_IDLE;
      r_mode      <= TT_MODE_SOP;
      r_mask      <= '0;
      r_row_valid <= 1'b0;
      r_row_out   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ones      <= '0;
    end else begin
      case (r_state)
        TT_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_mode      <= bus.mode;
            r_mask      <= bus.term_mask;
            r_ones      <= '0;
            r_row_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_row_out   <= tt_eval(bus.term_mask[0], bus.mode);
            r_state     <= TT_SWEEP;
          end
        end
        TT_SWEEP: begin
          if (w_hs) begin
            r_ones <= r_ones + {{N_VARS{1'b0}}, r_row_out};
            if (w_last) begin
              r_row_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_row_out   <= 1'b0;
              r_state     <= TT_DONE;
            end else begin
              r_row_out <= tt_eval(r_mask[w_next_idx], r_mode);
            end
          end
        end
        TT_DONE: begin
          r_done  <= 1'b1;
          r_state <= TT_IDLE;
        end
        default: r_state <= TT_IDLE;
      endcase
    end
  end

`ifdef TT_CHECK_EN
  logic [ROWS-1:0]  r_expect;
  logic [N_VARS:0]  r_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expect <= '0;
      r_mis    <= '0;
    end else if (w_start) begin
      r_expect <= bus.expect_mask;
      r_mis    <= '0;
    end else if ((r_state == TT_SWEEP) && w_hs && (r_row_out != r_expect[w_idx])) begin
      r_mis <= r_mis + (N_VARS+1)'(1);
    end
  end

  assign bus.mismatch_cnt = r_mis;
`endif

  assign bus.row_valid  = r_row_valid;
  assign bus.row_idx    = w_idx;
  assign bus.row_out    = r_row_out;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ones_count = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module  : tb_truth_table_sweeper
// Brief   : Directed self-checking bench for truth_table_sweeper (N_VARS=3).
//           TT_CHECK_EN enables the expect_mask / mismatch_cnt scenarios.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  truth_table_sweeper_if #(.N_VARS(3)) bus ();

  truth_table_sweeper #(.N_VARS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TT_CHECK_EN
  logic [7:0] tb_flip;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Full sweep with out_ready high; optional start/mask glitch while row glitch_at is shown.
  task automatic run_sweep(input logic mode, input logic [7:0] mask,
                           input logic [7:0] exp_rows, input int exp_ones,
                           input int glitch_at);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = mode;
    bus.term_mask = mask;
    bus.out_ready = 1'b1;
`ifdef TT_CHECK_EN
    bus.expect_mask = exp_rows ^ tb_flip;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.start = 1'b0;
      chk("row_valid", 32'(bus.row_valid), 32'd1);
      chk("row_idx",   32'(bus.row_idx),   32'(i));
      chk("row_out",   32'(bus.row_out),   32'(exp_rows[i]));
      chk("busy",      32'(bus.busy),      32'd1);
      if (i == glitch_at) begin
        bus.start     = 1'b1;
        bus.mode      = ~mode;
        bus.term_mask = ~mask;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("gap_done",  32'(bus.done),      32'd0);
    chk("gap_valid", 32'(bus.row_valid), 32'd0);
    chk("gap_idx",   32'(bus.row_idx),   32'd0);
    chk("gap_busy",  32'(bus.busy),      32'd0);
    @(negedge clk);
    chk("done",       32'(bus.done),       32'd1);
    chk("ones_count", 32'(bus.ones_count), 32'(exp_ones));
`ifdef TT_CHECK_EN
    chk("mismatch_cnt", 32'(bus.mismatch_cnt), 32'($countones(tb_flip)));
`endif
    @(negedge clk);
    chk("done_clear", 32'(bus.done),       32'd0);
    chk("ones_hold",  32'(bus.ones_count), 32'(exp_ones));
  endtask

  initial begin
    int hs;
    logic seen_done;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.term_mask = 8'h00;
    bus.out_ready = 1'b0;
`ifdef TT_CHECK_EN
    tb_flip         = 8'h00;
    bus.expect_mask = 8'h00;
`endif
    #13;
    chk("rst_valid", 32'(bus.row_valid),  32'd0);
    chk("rst_idx",   32'(bus.row_idx),    32'd0);
    chk("rst_out",   32'(bus.row_out),    32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_done",  32'(bus.done),       32'd0);
    chk("rst_ones",  32'(bus.ones_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // POS M(2,3,6,7) and its SOP equivalent
    run_sweep(1'b1, 8'b1100_1100, 8'b0011_0011, 4, -1);
    run_sweep(1'b0, 8'b0011_0011, 8'b0011_0011, 4, -1);

    // Backpressure: hold row 2 for three cycles
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = 1'b0;
    bus.term_mask = 8'b1010_0110;
    bus.out_ready = 1'b1;
`ifdef TT_CHECK_EN
    bus.expect_mask = 8'b1010_0110;
`endif
    @(negedge clk);
    bus.start = 1'b0;
    hs = 1;
    @(negedge clk);
    hs++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_idx",   32'(bus.row_idx),    32'd2);
      chk("bp_out",   32'(bus.row_out),    32'd1);
      chk("bp_ones",  32'(bus.ones_count), 32'd1);
      chk("bp_valid", 32'(bus.row_valid),  32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (bus.done) seen_done = 1'b1;
      else begin
        if (bus.row_valid && bus.out_ready) hs++;
        @(negedge clk);
      end
    end
    chk("bp_done_seen",  32'(seen_done),      32'd1);
    chk("bp_handshakes", 32'(hs),             32'd8);
    chk("bp_ones_final", 32'(bus.ones_count), 32'd4);
    @(negedge clk);

    // Mid-sweep start with different mask/mode is ignored
    run_sweep(1'b1, 8'b1100_1100, 8'b0011_0011, 4, 3);

    // Async reset while row 5 is shown
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = 1'b0;
    bus.term_mask = 8'b0011_0011;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_idx", 32'(bus.row_idx), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.row_valid),  32'd0);
    chk("arst_idx",   32'(bus.row_idx),    32'd0);
    chk("arst_out",   32'(bus.row_out),    32'd0);
    chk("arst_busy",  32'(bus.busy),       32'd0);
    chk("arst_done",  32'(bus.done),       32'd0);
    chk("arst_ones",  32'(bus.ones_count), 32'd0);
`ifdef TT_CHECK_EN
    chk("arst_mis",   32'(bus.mismatch_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b1, 8'b1100_1100, 8'b0011_0011, 4, -1);

`ifdef TT_CHECK_EN
    tb_flip = 8'h01;
    run_sweep(1'b1, 8'b1100_1100, 8'b0011_0011, 4, -1);
    tb_flip = 8'h00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
